// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizer plus two-state debounce FSM driving dout/doutbar
// Optional edge pulses (rise/fall) are built only when DEBOUNCE_EDGE_EN is defined.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic doutbar,
  output logic busy
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   toggle;

  assign sync_q = sync_ff[SYNC_STAGES-1];

  // Synchronizer chain: din enters at bit 0, only the last stage is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
    end
  end

  // State register: FSM state, counter and the dout/doutbar pair update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STABLE;
      cnt     <= '0;
      dout    <= 1'b0;
      doutbar <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (toggle) begin
        dout    <= ~dout;
        doutbar <= dout;
      end
    end
  end

  // Next-state logic: count consecutive mismatches, drop back to STABLE on a glitch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    toggle  = 1'b0;
    case (state)
      STABLE: begin
        cnt_n = '0;
        if (sync_q != dout) begin
          if (DEBOUNCE_CYCLES == 1) begin
            toggle = 1'b1;
          end else begin
            state_n = CHECK;
            cnt_n   = CW'(1);
          end
        end
      end
      CHECK: begin
        if (sync_q == dout) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          toggle  = 1'b1;
          state_n = STABLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    endcase
  end

  // Output logic: busy marks an in-progress check.
  always_comb begin
    busy = (state == CHECK);
  end

`ifdef DEBOUNCE_EDGE_EN
  // Edge pulses: registered on the same edge that flips dout, so they show the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= toggle & ~dout;
      fall <= toggle & dout;
    end
  end
`endif

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high; ports named clk and rst.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on din (legal ≥2).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, the consecutive mismatching samples required before dout changes (legal ≥1).
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port din, input, 1 bit: raw asynchronous level, e.g. a switch or button.
REQ-007 The block SHALL have port dout, output, 1 bit: the debounced level, which feeds the d input of the downstream D flip-flop.
REQ-008 The block SHALL have port doutbar, output, 1 bit: always the complement of dout.
REQ-009 The block SHALL have port busy, output, 1 bit: high while the FSM is in CHECK.
REQ-010 The block SHALL have port rise, output, 1 bit, present only with DEBOUNCE_EDGE_EN: one-cycle pulse on a dout 0->1 change.
REQ-011 The block SHALL have port fall, output, 1 bit, present only with DEBOUNCE_EDGE_EN: one-cycle pulse on a dout 1->0 change.

Function
REQ-012 din SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sync_q, and only sync_q drives the FSM.
REQ-013 The FSM SHALL have exactly two states: STABLE and CHECK. The counter width SHALL be clog2(DEBOUNCE_CYCLES+1).
REQ-014 In STABLE with sync_q == dout, the block SHALL hold state with cnt = 0.
REQ-015 In STABLE with sync_q != dout, the block SHALL do one of two things:
- if DEBOUNCE_CYCLES == 1, toggle dout on that edge and stay in STABLE;
- otherwise, go to CHECK with cnt = 1.
REQ-016 In CHECK with sync_q == dout (glitch), the block SHALL return to STABLE with cnt = 0, leave dout unchanged and produce no pulse.
REQ-017 In CHECK with sync_q != dout and cnt == DEBOUNCE_CYCLES-1, the block SHALL toggle dout, go to STABLE and set cnt = 0.
REQ-018 In CHECK with sync_q != dout and cnt < DEBOUNCE_CYCLES-1, the block SHALL increment cnt.
REQ-019 cnt SHALL never exceed DEBOUNCE_CYCLES-1; there SHALL be no wrap-around.
REQ-020 Latency SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges, counting the first edge that samples a new din value held stable, up to and including the edge that updates dout (defaults: 6).
REQ-021 din pulses shorter than DEBOUNCE_CYCLES cycles at sync_q SHALL never change dout.
REQ-022 doutbar SHALL be registered together with dout, never differ from ~dout and never be X after reset.
REQ-023 busy SHALL equal (state == CHECK).

Reset
REQ-024 When rst is high at a rising edge, the block SHALL reset as follows, with rst taking priority over every other event:
- all sync flops = 0;
- dout = 0, doutbar = 1;
- cnt = 0, state = STABLE, busy = 0;
- rise = 0, fall = 0.
REQ-025 Reset asserted during CHECK SHALL abort the check with no dout change and no pulse.
REQ-026 After rst is released with din = 1 held, dout SHALL rise after the REQ-020 latency, with a rise pulse when enabled.

Configuration
REQ-027 With macro DEBOUNCE_EDGE_EN defined, the following SHALL hold:
- rise and fall exist as registered outputs;
- each is high for exactly the one cycle following the edge on which dout changes in its direction;
- rise and fall are never high together.
REQ-028 Without DEBOUNCE_EDGE_EN, rise and fall and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL cover five scenarios at defaults (2/4), plus one at DEBOUNCE_CYCLES=1:
- Reset, then din 0->1 held: dout = 1 and doutbar = 0 exactly 6 edges after the first sampling edge; busy high for 3 cycles; one rise pulse.
- din = 1 held, dout = 1, then din low for 2 cycles: busy pulses, dout stays 1, no fall pulse.
- din toggles every cycle for 40 cycles: dout never changes; cnt never exceeds 3.
- rst asserted during CHECK (cnt = 2): next cycle dout = 0, busy = 0, cnt = 0, no pulse.
- Clean 1->0 edge from dout = 1: fall pulses for one cycle exactly 6 edges later; with DEBOUNCE_EDGE_EN undefined, the same dout timing holds.
- DEBOUNCE_CYCLES=1, din 0->1: dout rises after 3 edges; busy is never high.
